// File: rtl/exe_sequencer_pkg.sv
// Shared opcode, flag and state definitions for the execute sequencer.
package exe_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  localparam logic [4:0] OP_ADD    = 5'b00010;
  localparam logic [4:0] OP_ADDI   = 5'b00011;
  localparam logic [4:0] OP_SUB    = 5'b00100;
  localparam logic [4:0] OP_SUBI   = 5'b00101;
  localparam logic [4:0] OP_AND    = 5'b00110;
  localparam logic [4:0] OP_ANDI   = 5'b00111;
  localparam logic [4:0] OP_OR     = 5'b01000;
  localparam logic [4:0] OP_ORI    = 5'b01001;
  localparam logic [4:0] OP_XOR    = 5'b01010;
  localparam logic [4:0] OP_XORI   = 5'b01011;
  localparam logic [4:0] OP_NOT    = 5'b01100;
  localparam logic [4:0] OP_NOTI   = 5'b01101;
  localparam logic [4:0] OP_MOV    = 5'b01110;
  localparam logic [4:0] OP_MOVI   = 5'b01111;
  localparam logic [4:0] OP_MOVEQ  = 5'b10000;
  localparam logic [4:0] OP_MOVIEQ = 5'b10001;
  localparam logic [4:0] OP_MOVL   = 5'b10010;
  localparam logic [4:0] OP_MOVIL  = 5'b10011;
  localparam logic [4:0] OP_MOVG   = 5'b10100;
  localparam logic [4:0] OP_MOVIG  = 5'b10101;
  localparam logic [4:0] OP_LAD    = 5'b10110;
  localparam logic [4:0] OP_STR    = 5'b10111;
  localparam logic [4:0] OP_LSFT   = 5'b11100;
  localparam logic [4:0] OP_RSFT   = 5'b11101;

  localparam logic [1:0] FLAG_GT = 2'b11;
  localparam logic [1:0] FLAG_EQ = 2'b01;
  localparam logic [1:0] FLAG_LT = 2'b10;

  function automatic logic is_legal(input logic [4:0] op);
    return !(op inside {5'b00000, 5'b00001, 5'b11000, 5'b11001,
                        5'b11010, 5'b11011, 5'b11110, 5'b11111});
  endfunction

  // Non-conditional opcodes always pass.
  function automatic logic cond_pass(input logic [4:0] op, input logic [1:0] flg);
    case (op)
      OP_MOVEQ, OP_MOVIEQ: return flg == FLAG_EQ;
      OP_MOVL,  OP_MOVIL:  return flg == FLAG_LT;
      OP_MOVG,  OP_MOVIG:  return flg == FLAG_GT;
      default:             return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/exe_sequencer_mem_wait_timer.sv
// Clearable saturating wait counter; expired flags the last allowed wait cycle.
module mem_wait_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count_en && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == CW'(LIMIT - 1));

endmodule

// File: rtl/exe_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer around the ALU, owning the
// result/flag feedback registers and the memory handshakes.
module exe_sequencer
  import exe_sequencer_pkg::*;
#(
  parameter int unsigned OPW         = 5,
  parameter int unsigned DW          = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic [OPW-1:0] opcode,
  output logic          imem_req,
  input  logic          imem_ready,
  output logic          dmem_req,
  output logic          dmem_we,
  input  logic          dmem_ready,
  output logic          en_decode,
  output logic          en_exe_pulse,
  input  logic [DW-1:0] alu_result,
  input  logic [1:0]    flag,
  output logic [DW-1:0] alu_result_reg,
  output logic [1:0]    flag_reg,
  output logic          pc_inc,
  output logic          rf_we,
  output logic          wb_sel_mem,
  output logic          illegal_op,
  output logic          bus_err,
  output logic [31:0]   retired
);

  state_t         state_q, state_d;
  logic [OPW-1:0] op_q;
  logic           retire;
  logic           cond_ok;
  logic           is_mem_op;
  logic           expired;
  logic           wait_en;

  assign cond_ok   = cond_pass(op_q, flag_reg);
  assign is_mem_op = (op_q == OP_LAD) || (op_q == OP_STR);
  assign wait_en   = ((state_q == S_FETCH) && !imem_ready) ||
                     ((state_q == S_MEM)   && !dmem_ready);

  mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (state_d != state_q),
    .count_en (wait_en),
    .expired  (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Retirement is a transition event, so it is produced alongside next-state.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ready)   state_d = S_DECODE;
        else if (expired) state_d = S_IDLE;
      end
      S_DECODE: begin
        if (is_legal(opcode)) state_d = S_EXEC;
        else                  state_d = run ? S_FETCH : S_IDLE;
      end
      S_EXEC: begin
        if (is_mem_op)    state_d = S_MEM;
        else if (cond_ok) state_d = S_WB;
        else begin
          retire  = 1'b1;
          state_d = run ? S_FETCH : S_IDLE;
        end
      end
      S_MEM: begin
        if (dmem_ready) begin
          if (op_q == OP_LAD) state_d = S_WB;
          else begin
            retire  = 1'b1;
            state_d = run ? S_FETCH : S_IDLE;
          end
        end else if (expired) begin
          state_d = S_IDLE;
        end
      end
      S_WB: begin
        retire  = 1'b1;
        state_d = run ? S_FETCH : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req     = 1'b0;
    pc_inc       = 1'b0;
    en_decode    = 1'b0;
    illegal_op   = 1'b0;
    en_exe_pulse = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    rf_we        = 1'b0;
    wb_sel_mem   = 1'b0;
    bus_err      = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        pc_inc   = imem_ready;
        bus_err  = !imem_ready && expired;
      end
      S_DECODE: begin
        en_decode  = 1'b1;
        illegal_op = !is_legal(opcode);
      end
      S_EXEC: en_exe_pulse = 1'b1;
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op_q == OP_STR);
        bus_err  = !dmem_ready && expired;
      end
      S_WB: begin
        rf_we      = 1'b1;
        wb_sel_mem = (op_q == OP_LAD);
      end
      default: ;
    endcase
  end

  // A false conditional move leaves the result register untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q           <= '0;
      alu_result_reg <= '0;
      flag_reg       <= '0;
      retired        <= '0;
    end else begin
      if (state_q == S_DECODE) op_q <= opcode;
      if (state_q == S_EXEC) begin
        if (cond_ok) alu_result_reg <= alu_result;
        if ((op_q == OP_SUB) || (op_q == OP_SUBI)) flag_reg <= flag;
      end
      if (retire) retired <= retired + 32'd1;
    end
  end

endmodule
